// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: resolves load-use, taken-branch
// and multi-cycle data-memory hazards, and tracks stall cycles and memory timeouts.
module pipeline_ctrl #(
  parameter int CNT_W      = 16,
  parameter int WAIT_LIMIT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_Rn,
  input  logic [4:0]       id_Rm,
  input  logic             id_uses_Rn,
  input  logic             id_uses_Rm,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_Rd,
  input  logic             ex_branch_taken,
  input  logic             mem_access,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             mem_wb_bubble,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             mem_timeout
);

  localparam int WC_W = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam logic [WC_W-1:0]  WC_MAX  = WC_W'(WAIT_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_WAIT = 1'b1} state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [WC_W-1:0]   wait_cnt_r;
  logic [CNT_W-1:0]  stall_cycles_r;
  logic              mem_timeout_r;
  logic              mem_stall_s;
  logic              req_s;
  logic              load_use_s;
  logic              wait_miss_s;

  // Register 31 is XZR, so a load targeting it never creates a dependency.
  assign load_use_s = ex_mem_read & (ex_Rd != 5'd31) &
                      ((id_uses_Rn & (id_Rn == ex_Rd)) | (id_uses_Rm & (id_Rm == ex_Rd)));
  assign wait_miss_s  = (state_r == ST_WAIT) & ~dmem_ready;
  assign stall_cycles = stall_cycles_r;
  assign mem_timeout  = mem_timeout_r;

  // Next-state logic and memory-stall detection
  always_comb begin
    state_nxt_s = state_r;
    mem_stall_s = 1'b0;
    req_s       = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (mem_access) begin
          mem_stall_s = 1'b1;
          req_s       = 1'b1;
          state_nxt_s = ST_WAIT;
        end else begin
          mem_stall_s = 1'b0;
        end
      end
      ST_WAIT: begin
        if (dmem_ready) begin
          state_nxt_s = ST_RUN;
        end else begin
          mem_stall_s = 1'b1;
        end
      end
      default: state_nxt_s = ST_RUN;
    endcase
  end

  // Pipeline control outputs, priority memory stall > branch flush > load-use
  always_comb begin
    dmem_req      = 1'b0;
    pc_en         = 1'b0;
    if_id_en      = 1'b0;
    id_ex_en      = 1'b0;
    ex_mem_en     = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    mem_wb_bubble = 1'b0;
    if (!rst) begin
      dmem_req = 1'b0;
    end else if (mem_stall_s) begin
      dmem_req      = req_s;
      mem_wb_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      pc_en        = 1'b1;
      if_id_en     = 1'b1;
      id_ex_en     = 1'b1;
      ex_mem_en    = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (load_use_s) begin
      id_ex_en     = 1'b1;
      ex_mem_en    = 1'b1;
      id_ex_bubble = 1'b1;
    end else begin
      pc_en     = 1'b1;
      if_id_en  = 1'b1;
      id_ex_en  = 1'b1;
      ex_mem_en = 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // WAIT-cycle counter, cleared on the request cycle and saturating at the limit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_r <= '0;
    end else if ((state_r == ST_RUN) && mem_access) begin
      wait_cnt_r <= '0;
    end else if (wait_miss_s && (wait_cnt_r != WC_MAX)) begin
      wait_cnt_r <= wait_cnt_r + WC_W'(1);
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  // Sticky timeout, set on the edge where the WAIT counter reaches the limit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_timeout_r <= 1'b0;
    end else if (wait_miss_s && (wait_cnt_r == (WC_MAX - WC_W'(1)))) begin
      mem_timeout_r <= 1'b1;
    end else begin
      mem_timeout_r <= mem_timeout_r;
    end
  end

  // Saturating count of cycles in which the PC is held
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_r <= '0;
    end else if (!pc_en && (stall_cycles_r != CNT_MAX)) begin
      stall_cycles_r <= stall_cycles_r + CNT_W'(1);
    end else begin
      stall_cycles_r <= stall_cycles_r;
    end
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the 5-stage 64-bit ARM pipeline. It drives the enable, bubble and flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC. It resolves three hazards: load-use hazards, taken branches resolved in EX, and multi-cycle data-memory accesses through a req/ready handshake. It also keeps a saturating stall-cycle counter and a sticky memory-timeout flag.

## Interface
- CNT_W, 16, width of the stall-cycle counter
- WAIT_LIMIT, 255, WAIT cycles before mem_timeout sets (≥1)

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- id_Rn, id_Rm  in  5 each  source registers of the instruction in ID
- id_uses_Rn, id_uses_Rm  in  1 each  source actually read
- ex_mem_read  in  1  instruction in EX is a load
- ex_Rd  in  5  destination of the instruction in EX
- ex_branch_taken  in  1  branch in EX resolved taken
- mem_access  in  1  instruction in MEM is a load or store
- dmem_ready  in  1  data memory done; sampled only in WAIT
- dmem_req  out  1  one-cycle request pulse to data memory
- pc_en, if_id_en, id_ex_en, ex_mem_en  out  1 each  register load enables
- if_id_flush  out  1  IF/ID loads NOP
- id_ex_bubble  out  1  ID/EX loads zero control (bubble)
- mem_wb_bubble  out  1  MEM/WB loads zero WB control
- stall_cycles  out  CNT_W  count of cycles with pc_en=0, saturating
- mem_timeout  out  1  sticky: a WAIT lasted WAIT_LIMIT cycles

## Operation
- FSM states: RUN, WAIT.
- RUN with mem_access=1:
  - dmem_req=1 for this cycle; next state WAIT.
  - Memory stall applies this cycle.
- WAIT with dmem_ready=0:
  - Memory stall applies; stay in WAIT; wait_cnt increments.
- WAIT with dmem_ready=1:
  - Release cycle: all enables 1, mem_wb_bubble=0; next state RUN.
- Memory stall outputs: pc_en = if_id_en = id_ex_en = ex_mem_en = 0; mem_wb_bubble=1; if_id_flush = id_ex_bubble = 0.
- Priority (highest first): memory stall > branch flush > load-use.
  - During a memory stall, a pending ex_branch_taken or load-use is deferred. EX is frozen, so it re-evaluates on the release cycle.
- Branch flush: if_id_flush=1, id_ex_bubble=1; all enables 1, so the PC loads the target.
  - Branch flush overrides load-use in the same cycle, because the ID instruction is wrong-path.
- Load-use condition: ex_mem_read & ex_Rd≠31 & ((id_uses_Rn & id_Rn==ex_Rd) | (id_uses_Rm & id_Rm==ex_Rd)).
  - Response: pc_en=0, if_id_en=0, id_ex_en=1, id_ex_bubble=1, ex_mem_en=1.
- Release cycle is evaluated like RUN for the branch flush and load-use rules, but issues no new dmem_req.
- Default (no condition): all enables 1; flush/bubble/dmem_req 0.
- stall_cycles: +1 on every cycle with pc_en=0 and rst=1; holds at 2^CNT_W−1.
- mem_timeout: sets when wait_cnt reaches WAIT_LIMIT.
  - Stays set until reset.
  - The pipeline stays frozen; there is no forced exit from WAIT.
- wait_cnt: clears on entering WAIT; saturates at WAIT_LIMIT.

## Timing
- Reset (rst=0), asynchronous:
  - state=RUN; wait_cnt=0; stall_cycles=0; mem_timeout=0.
  - All outputs 0, including every enable, for as long as rst=0.
- All control outputs are combinational from state and inputs, valid before the clk edge where the registers capture.
- Memory access latency:
  - Minimum: 2 cycles, a req cycle then a ready cycle in WAIT.
  - dmem_ready asserted in the req cycle is ignored.
- Each memory access adds (cycles in WAIT) stall cycles to stall_cycles: 1 for the req cycle plus the WAIT cycles with ready=0.
  - The release cycle is not counted.
- Load-use: exactly 1 stall cycle. Next cycle the load is in MEM, so the condition clears.
  - If that load then stalls MEM, the memory stall takes over.
- Branch flush: 1 cycle, 2 bubbles (IF/ID and ID/EX).
- rst asserted while in WAIT: immediate return to RUN, dmem_req=0, no request reissued.

## Test plan
- Reset mid-WAIT → outputs 0 asynchronously; after rst=1: RUN, stall_cycles=0, mem_timeout=0; ready from the old request has no effect.
- Load-use: ex_mem_read=1, ex_Rd=5, id_Rn=5, id_uses_Rn=1 → 1 cycle with pc_en=0, if_id_en=0, id_ex_bubble=1; stall_cycles=1. Repeat with ex_Rd=31 → no stall.
- Branch and load-use together: ex_branch_taken=1 with a load-use condition → if_id_flush=1, id_ex_bubble=1, pc_en=1.
- Memory access: mem_access=1, dmem_ready rises 3 cycles after req → dmem_req a single 1-cycle pulse; 3 stall cycles (req cycle plus 2 WAIT cycles with ready=0) with mem_wb_bubble=1; release cycle ex_mem_en=1; stall_cycles +=3.
- Branch pending during memory wait: ex_branch_taken=1 while WAIT → no flush until the release cycle, then if_id_flush=1 exactly once.
- Timeout and saturation: WAIT_LIMIT=4, dmem_ready held 0 → mem_timeout=1 after 4 WAIT cycles, stays 1 after release. CNT_W=4 with 20 stall cycles → stall_cycles=15.
